// File: rtl/aes256_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes256_pkg
// Desc     : Shared sizes, host FSM states and byte-slice helper for AES hosts.
// Revision : 1.0
// ============================================================================
package aes256_pkg;

    localparam int AES_BLOCK_BYTES  = 16;
    localparam int AES256_KEY_BYTES = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        KEY_LOAD = 3'd1,
        BLK_LOAD = 3'd2,
        START    = 3'd3,
        WAIT     = 3'd4,
        DRAIN    = 3'd5
    } host_state_t;

    // Byte 0 is the most significant byte of the block or key.
    function automatic logic [7:0] byte_lsb(input logic [4:0] idx, input logic is_key);
        logic [4:0] last;
        last = is_key ? 5'(AES256_KEY_BYTES - 1) : 5'(AES_BLOCK_BYTES - 1);
        return {last - idx, 3'b000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes256_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module   : aes256_byte_serializer
// Desc     : 128-bit load/shift register streaming 16 bytes out MSB first.
// Revision : 1.0
// ============================================================================
module aes256_byte_serializer
    import aes256_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [127:0] data_i,
    output logic [7:0]   out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         done_o
);

    localparam logic [3:0] LAST_BYTE = 4'(AES_BLOCK_BYTES - 1);

    logic [127:0] shift_q, shift_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         valid_q, valid_d;
    logic         w_fire;

    assign w_fire      = valid_q & out_ready_i;
    assign out_data_o  = shift_q[127:120];
    assign out_valid_o = valid_q;
    assign done_o      = w_fire && (cnt_q == LAST_BYTE);

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = 4'd0;
            valid_d = 1'b1;
        end else if (w_fire) begin
            shift_d = {shift_q[119:0], 8'h00};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == LAST_BYTE) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/aes256_byte_host.sv
`default_nettype none
// ============================================================================
// Module   : aes256_byte_host
// Desc     : Byte-stream front end that loads key/block, starts aes256_core
//            and streams the 16-byte result back out.
// Revision : 1.0
// ============================================================================
module aes256_byte_host
    import aes256_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_key_i,
    input  logic         mode_i,
    input  logic [7:0]   in_data_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    output logic [7:0]   out_data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         core_start_o,
    output logic         core_mode_o,
    output logic [127:0] core_text_o,
    output logic [255:0] core_key_o,
    input  logic [127:0] core_result_i,
    input  logic         core_valid_i,
    input  logic         core_busy_i,
    output logic         key_loaded_o,
    output logic         busy_o,
    output logic         err_o
);

    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       KEY_LAST  = 5'(AES256_KEY_BYTES - 1);
    localparam logic [3:0]       BLK_LAST  = 4'(AES_BLOCK_BYTES - 1);

    host_state_t      state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;
    logic [255:0]     key_q, key_d;
    logic [127:0]     text_q, text_d;
    logic             mode_q, mode_d;
    logic             key_loaded_q, key_loaded_d;
    logic             err_q, err_d;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_start;
    logic             w_ser_load;
    logic             w_ser_done;

    // A key-load request in IDLE wins over a byte offered in the same cycle.
    assign w_in_ready = ((state_q == IDLE) && key_loaded_q && !load_key_i) ||
                        (state_q == KEY_LOAD) || (state_q == BLK_LOAD);
    assign w_in_fire  = in_valid_i & w_in_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tmo_d        = tmo_q;
        key_d        = key_q;
        text_d       = text_q;
        mode_d       = mode_q;
        key_loaded_d = key_loaded_q;
        err_d        = err_q;
        w_start      = 1'b0;
        w_ser_load   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_key_i) begin
                    state_d      = KEY_LOAD;
                    cnt_d        = 5'd0;
                    key_loaded_d = 1'b0;
                end else if (w_in_fire) begin
                    mode_d = mode_i;
                    text_d[byte_lsb(5'd0, 1'b0) +: 8] = in_data_i;
                    cnt_d   = 5'd1;
                    state_d = BLK_LOAD;
                end
            end
            KEY_LOAD: begin
                if (w_in_fire) begin
                    key_d[byte_lsb(cnt_q, 1'b1) +: 8] = in_data_i;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == KEY_LAST) begin
                        key_loaded_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            BLK_LOAD: begin
                if (w_in_fire) begin
                    text_d[byte_lsb({1'b0, cnt_q[3:0]}, 1'b0) +: 8] = in_data_i;
                    cnt_d = {1'b0, cnt_q[3:0] + 4'd1};
                    if (cnt_q[3:0] == BLK_LAST) begin
                        state_d = START;
                    end
                end
            end
            START: begin
                if (!core_busy_i) begin
                    w_start = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (core_valid_i) begin
                    w_ser_load = 1'b1;
                    state_d    = DRAIN;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            DRAIN: begin
                if (w_ser_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tmo_q        <= '0;
            key_q        <= '0;
            text_q       <= '0;
            mode_q       <= 1'b0;
            key_loaded_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tmo_q        <= tmo_d;
            key_q        <= key_d;
            text_q       <= text_d;
            mode_q       <= mode_d;
            key_loaded_q <= key_loaded_d;
            err_q        <= err_d;
        end
    end

    aes256_byte_serializer u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (w_ser_load),
        .data_i      (core_result_i),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .done_o      (w_ser_done)
    );

    assign in_ready_o   = w_in_ready;
    assign core_start_o = w_start;
    assign core_mode_o  = mode_q;
    assign core_text_o  = text_q;
    assign core_key_o   = key_q;
    assign key_loaded_o = key_loaded_q;
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes256_byte_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes256_byte_host
// Desc     : Self-checking bench for aes256_byte_host with a stub AES core.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_aes256_byte_host;

    localparam int TIMEOUT_CYCLES = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         load_key_i, mode_i, in_valid_i, out_ready_i;
    logic [7:0]   in_data_i;
    logic         in_ready_o, out_valid_o, core_start_o, core_mode_o;
    logic [7:0]   out_data_o;
    logic [127:0] core_text_o, core_result_i;
    logic [255:0] core_key_o;
    logic         core_valid_i, core_busy_i;
    logic         key_loaded_o, busy_o, err_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    aes256_byte_host #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(7)) dut (
        .clk(clk), .rst(rst), .load_key_i(load_key_i), .mode_i(mode_i),
        .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .core_start_o(core_start_o), .core_mode_o(core_mode_o), .core_text_o(core_text_o),
        .core_key_o(core_key_o), .core_result_i(core_result_i), .core_valid_i(core_valid_i),
        .core_busy_i(core_busy_i), .key_loaded_o(key_loaded_o), .busy_o(busy_o), .err_o(err_o)
    );

    // Stand-in cipher: keyed byte rotation, invertible so decrypt undoes encrypt.
    function automatic logic [127:0] core_model(input logic [127:0] t, input logic [255:0] k,
                                                input logic m);
        logic [127:0] kx, x;
        kx = k[255:128] ^ k[127:0];
        if (!m) begin
            x = {t[119:0], t[127:120]} ^ kx;
        end else begin
            x = t ^ kx;
            x = {x[7:0], x[127:8]};
        end
        return x;
    endfunction

    logic         stub_respond, spur_en, force_busy;
    logic [3:0]   stub_lat;
    logic         stub_busy_q  = 1'b0;
    logic         stub_valid_q = 1'b0;
    logic [3:0]   lat_cnt_q    = 4'd0;
    logic [127:0] stub_res_q   = '0;
    int           start_count  = 0;

    assign core_busy_i   = stub_busy_q | force_busy;
    assign core_valid_i  = stub_valid_q | (spur_en & core_start_o);
    assign core_result_i = (spur_en & core_start_o) ? 128'hDEAD_BEEF_0BAD_F00D_DEAD_BEEF_0BAD_F00D
                                                    : stub_res_q;

    always @(posedge clk) begin
        stub_valid_q <= 1'b0;
        if (core_start_o) start_count <= start_count + 1;
        if (rst) begin
            stub_busy_q <= 1'b0;
            lat_cnt_q   <= 4'd0;
        end else if (core_start_o) begin
            if (stub_respond) begin
                stub_busy_q <= 1'b1;
                lat_cnt_q   <= stub_lat;
                stub_res_q  <= core_model(core_text_o, core_key_o, core_mode_o);
            end
        end else if (stub_busy_q) begin
            if (lat_cnt_q == 4'd0) begin
                stub_valid_q <= 1'b1;
                stub_busy_q  <= 1'b0;
            end else begin
                lat_cnt_q <= lat_cnt_q - 4'd1;
            end
        end
    end

    logic [255:0] key_cur;

    task automatic send_byte(input logic [7:0] b, input logic m);
        int t = 0;
        in_data_i  = b;
        mode_i     = m;
        in_valid_i = 1'b1;
        #1;
        while (!in_ready_o && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (!in_ready_o) begin
            total_cnt++;
            $display("FAIL in_handshake: in_ready_o=%b required 1 within 200 cycles", in_ready_o);
        end
        @(negedge clk);
        in_valid_i = 1'b0;
    endtask

    task automatic load_key(input logic [255:0] k, input bit poke);
        load_key_i = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 8'($urandom);
        #1;
        total_cnt++;
        if (in_ready_o !== 1'b0) $display("FAIL load_key_priority: in_ready_o=%b required 0", in_ready_o);
        else pass_cnt++;
        @(negedge clk);
        load_key_i = 1'b0;
        in_valid_i = 1'b0;
        #1;
        total_cnt++;
        if (key_loaded_o !== 1'b0) $display("FAIL key_loaded_clear: key_loaded_o=%b required 0", key_loaded_o);
        else pass_cnt++;
        for (int i = 0; i < 32; i++) begin
            if (poke && i == 10) load_key_i = 1'b1;
            send_byte(k[255-8*i -: 8], 1'b0);
            load_key_i = 1'b0;
        end
        #1;
        total_cnt++;
        if (key_loaded_o !== 1'b1) $display("FAIL key_loaded_set: key_loaded_o=%b required 1", key_loaded_o);
        else pass_cnt++;
        total_cnt++;
        if (core_key_o !== k) $display("FAIL key_assembly: core_key_o=%h required %h", core_key_o, k);
        else pass_cnt++;
        key_cur = k;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic m, input bit gaps, input bit poke);
        for (int i = 0; i < 16; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            if (poke && i == 5) load_key_i = 1'b1;
            send_byte(blk[127-8*i -: 8], (i == 0) ? m : 1'($urandom));
            load_key_i = 1'b0;
        end
    endtask

    // pat: 0 = always ready, 1 = one cycle on / three off, 2 = random
    task automatic collect(input logic [127:0] exp_r, input int pat, input string name);
        int idx = 0;
        int cyc = 0;
        logic rdy;
        while (idx < 16 && cyc < 2000) begin
            rdy = (pat == 0) ? 1'b1 : (pat == 1) ? (cyc % 4 == 0) : 1'($urandom_range(0, 1));
            out_ready_i = rdy;
            #1;
            if (out_valid_o) begin
                total_cnt++;
                if (out_data_o !== exp_r[127-8*idx -: 8])
                    $display("FAIL %s byte%0d: out_data_o=%h required %h", name, idx, out_data_o,
                             exp_r[127-8*idx -: 8]);
                else pass_cnt++;
                if (rdy) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready_i = 1'b0;
        #1;
        total_cnt++;
        if (idx != 16) $display("FAIL %s drain_count: got %0d bytes required 16", name, idx);
        else pass_cnt++;
        total_cnt++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL %s after_drain: out_valid_o=%b busy_o=%b required 0 0", name, out_valid_o, busy_o);
        else pass_cnt++;
    endtask

    task automatic run_block(input logic [127:0] blk, input logic m, input logic [127:0] exp_r,
                             input int pat, input bit gaps, input bit poke, input string name);
        int s0 = start_count;
        send_block(blk, m, gaps, poke);
        collect(exp_r, pat, name);
        total_cnt++;
        if (start_count - s0 != 1) $display("FAIL %s start_pulses: got %0d required 1", name, start_count - s0);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({in_ready_o, out_valid_o, core_start_o, core_mode_o, key_loaded_o, busy_o, err_o} !== 7'b0)
            $display("FAIL reset_flags: rdy=%b vld=%b start=%b mode=%b kl=%b busy=%b err=%b required 0",
                     in_ready_o, out_valid_o, core_start_o, core_mode_o, key_loaded_o, busy_o, err_o);
        else pass_cnt++;
        total_cnt++;
        if (core_text_o !== '0 || core_key_o !== '0)
            $display("FAIL reset_data: text=%h key=%h required 0", core_text_o, core_key_o);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_no_key();
        int s0 = start_count;
        int hits = 0;
        for (int i = 0; i < 50; i++) begin
            in_valid_i = 1'b1;
            in_data_i  = 8'($urandom);
            mode_i     = 1'($urandom);
            #1;
            if (in_ready_o) hits++;
            @(negedge clk);
        end
        in_valid_i = 1'b0;
        total_cnt++;
        if (hits != 0) $display("FAIL no_key_ready: in_ready_o high %0d cycles required 0", hits);
        else pass_cnt++;
        total_cnt++;
        if (start_count != s0 || busy_o !== 1'b0)
            $display("FAIL no_key_start: starts=%0d busy_o=%b required 0 0", start_count - s0, busy_o);
        else pass_cnt++;
    endtask

    task automatic test_encrypt();
        logic [255:0] k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
        load_key(k, 1'b0);
        run_block(pt, 1'b0, core_model(pt, k, 1'b0), 0, 1'b0, 1'b0, "encrypt");
        total_cnt++;
        if (core_mode_o !== 1'b0) $display("FAIL encrypt_mode: core_mode_o=%b required 0", core_mode_o);
        else pass_cnt++;
    endtask

    task automatic test_decrypt();
        logic [127:0] pt = 128'h00112233445566778899aabbccddeeff;
        logic [127:0] ct = core_model(pt, key_cur, 1'b0);
        run_block(ct, 1'b1, pt, 0, 1'b0, 1'b0, "decrypt");
        total_cnt++;
        if (core_mode_o !== 1'b1) $display("FAIL decrypt_mode: core_mode_o=%b required 1", core_mode_o);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        run_block(pt, 1'b0, core_model(pt, key_cur, 1'b0), 1, 1'b0, 1'b0, "backpressure");
    endtask

    task automatic test_back_to_back();
        logic [255:0] k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        logic [127:0] pt;
        logic         m;
        load_key(k, 1'b1);
        spur_en = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pt       = {$urandom, $urandom, $urandom, $urandom};
            m        = 1'($urandom);
            stub_lat = 4'($urandom_range(0, 5));
            run_block(pt, m, core_model(pt, key_cur, m), 2, n[0], n == 1, "back_to_back");
        end
        spur_en  = 1'b0;
        stub_lat = 4'd0;
    endtask

    task automatic test_busy_hold();
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        int s0 = start_count;
        force_busy = 1'b1;
        send_block(pt, 1'b0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        #1;
        total_cnt++;
        if (start_count != s0 || busy_o !== 1'b1 || out_valid_o !== 1'b0)
            $display("FAIL busy_hold: starts=%0d busy_o=%b out_valid_o=%b required 0 1 0",
                     start_count - s0, busy_o, out_valid_o);
        else pass_cnt++;
        force_busy = 1'b0;
        collect(core_model(pt, key_cur, 1'b0), 0, "busy_hold");
        total_cnt++;
        if (start_count - s0 != 1) $display("FAIL busy_hold_start: got %0d required 1", start_count - s0);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        int  k = 0;
        bit  sawv = 1'b0;
        stub_respond = 1'b0;
        send_block(pt, 1'b0, 1'b0, 1'b0);
        #1;
        // Counted from the START cycle, so one more than the WAIT budget.
        while (!err_o && k < 200) begin
            @(negedge clk); #1; k++;
            if (out_valid_o) sawv = 1'b1;
        end
        total_cnt++;
        if (k != TIMEOUT_CYCLES + 1) $display("FAIL timeout_cycles: err after %0d cycles required %0d", k, TIMEOUT_CYCLES + 1);
        else pass_cnt++;
        total_cnt++;
        if (err_o !== 1'b1 || busy_o !== 1'b0 || sawv || key_loaded_o !== 1'b1)
            $display("FAIL timeout_state: err=%b busy=%b saw_valid=%b key_loaded=%b required 1 0 0 1",
                     err_o, busy_o, sawv, key_loaded_o);
        else pass_cnt++;
        stub_respond = 1'b1;
        pt = {$urandom, $urandom, $urandom, $urandom};
        run_block(pt, 1'b1, core_model(pt, key_cur, 1'b1), 0, 1'b0, 1'b0, "after_timeout");
        total_cnt++;
        if (err_o !== 1'b1) $display("FAIL err_sticky: err_o=%b required 1", err_o);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_drain();
        logic [127:0] pt = {$urandom, $urandom, $urandom, $urandom};
        logic [127:0] ex = core_model(pt, key_cur, 1'b0);
        int got = 0;
        int cyc = 0;
        send_block(pt, 1'b0, 1'b0, 1'b0);
        while (got < 8 && cyc < 200) begin
            out_ready_i = 1'b1;
            #1;
            if (out_valid_o) begin
                total_cnt++;
                if (out_data_o !== ex[127-8*got -: 8])
                    $display("FAIL mid_drain byte%0d: out_data_o=%h required %h", got, out_data_o, ex[127-8*got -: 8]);
                else pass_cnt++;
                got++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({out_valid_o, key_loaded_o, busy_o, in_ready_o, err_o} !== 5'b0 || core_key_o !== '0)
            $display("FAIL reset_mid_drain: vld=%b kl=%b busy=%b rdy=%b err=%b key=%h required all 0",
                     out_valid_o, key_loaded_o, busy_o, in_ready_o, err_o, core_key_o);
        else pass_cnt++;
        rst = 1'b0;
        in_valid_i = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (in_ready_o !== 1'b0) $display("FAIL post_reset_ready: in_ready_o=%b required 0", in_ready_o);
        else pass_cnt++;
        in_valid_i = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        load_key_i   = 1'b0;
        mode_i       = 1'b0;
        in_valid_i   = 1'b0;
        in_data_i    = 8'h00;
        out_ready_i  = 1'b0;
        stub_respond = 1'b1;
        spur_en      = 1'b0;
        force_busy   = 1'b0;
        stub_lat     = 4'd0;
        key_cur      = '0;
        @(negedge clk);
        test_reset();
        test_no_key();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_busy_hold();
        test_timeout();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
